pc_sequencer: RTL and testbench

- Fetch-stage program counter for the 16-bit MIPS core.
- Directly consumes the jump-register decode flag (jr_control) from the execute-stage control logic, plus the jump and taken-branch flags.
- Selects and registers the next PC and drives the instruction-memory fetch request with a valid/ready handshake.
- Emits a one-cycle flush to the IF/ID register whenever control flow is redirected.

---
 rtl/pc_sequencer.sv | 117 +++++++++++
 tb/tb_pc_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch-stage PC register with JR/jump/branch redirect and a
//            valid/ready instruction-fetch request.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        jr_control,
   input  logic [15:0] jr_addr,
   input  logic        jump,
   input  logic [12:0] jump_field,
   input  logic        branch_taken,
   input  logic [6:0]  branch_imm,
   input  logic [15:0] ex_pc_plus2,
   input  logic        if_ready,
   output logic        if_valid,
   output logic [15:0] pc_o,
   output logic [15:0] pc_plus2_o,
   output logic        flush,
   output logic        redirect_pend
);

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2
   } state_t;

   localparam logic [15:0] c_reset_pc = RESET_PC & 16'hFFFE;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_pc, w_pc_nxt;
   logic [15:0] r_pending, w_pending_nxt;
   logic        r_flush;

   logic        w_accept;
   logic        w_redir;
   logic [15:0] w_br_off;
   logic [15:0] w_target;

   assign if_valid      = (r_state != S_RST);
   assign redirect_pend = (r_state == S_PEND);
   assign pc_o          = r_pc;
   assign pc_plus2_o    = r_pc + 16'd2;
   assign flush         = r_flush;

   assign w_accept = if_valid & if_ready;
   // Redirect flags are ignored while the fetch port is idle after reset.
   assign w_redir  = if_valid & (jr_control | jump | branch_taken);
   assign w_br_off = {{8{branch_imm[6]}}, branch_imm, 1'b0};

   always_comb begin
      w_target = ex_pc_plus2 + w_br_off;
      if (jr_control)
         w_target = jr_addr & 16'hFFFE;
      else if (jump)
         w_target = {ex_pc_plus2[15:14], jump_field, 1'b0};
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_pending_nxt = r_pending;
      case (r_state)
         S_RST: w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_redir) begin
               // A stalled fetch is discarded anyway, so the PC may move.
               if (w_accept || stall) begin
                  w_pc_nxt = w_target;
               end else begin
                  w_pending_nxt = w_target;
                  w_state_nxt   = S_PEND;
               end
            end else if (w_accept && !stall) begin
               w_pc_nxt = r_pc + 16'd2;
            end
         end
         S_PEND: begin
            if (w_redir) begin
               if (w_accept) begin
                  w_pc_nxt    = w_target;
                  w_state_nxt = S_RUN;
               end else begin
                  w_pending_nxt = w_target;
               end
            end else if (w_accept) begin
               w_pc_nxt    = r_pending;
               w_state_nxt = S_RUN;
            end
         end
         default: w_state_nxt = S_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_RST;
         r_pc      <= c_reset_pc;
         r_pending <= 16'h0000;
         r_flush   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_pending <= w_pending_nxt;
         r_flush   <= w_redir;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed, scoreboard-checked bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, stall, jr_control, jump, branch_taken, if_ready;
   logic [15:0] jr_addr, ex_pc_plus2;
   logic [12:0] jump_field;
   logic [6:0]  branch_imm;
   logic        if_valid, flush, redirect_pend;
   logic [15:0] pc_o, pc_plus2_o;

   typedef struct {
      logic [15:0] pc;
      logic        valid;
      logic        flush;
      logic        pend;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .jr_control(jr_control),
      .jr_addr(jr_addr), .jump(jump), .jump_field(jump_field),
      .branch_taken(branch_taken), .branch_imm(branch_imm),
      .ex_pc_plus2(ex_pc_plus2), .if_ready(if_ready), .if_valid(if_valid),
      .pc_o(pc_o), .pc_plus2_o(pc_plus2_o), .flush(flush),
      .redirect_pend(redirect_pend)
   );

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: compares the post-edge DUT outputs against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp("pc_o", pc_o, e.pc);
            cmp("pc_plus2_o", pc_plus2_o, e.pc + 16'd2);
            cmp("if_valid", {15'd0, if_valid}, {15'd0, e.valid});
            cmp("flush", {15'd0, flush}, {15'd0, e.flush});
            cmp("redirect_pend", {15'd0, redirect_pend}, {15'd0, e.pend});
         end
      end
   end

   task automatic tick(input logic [15:0] pc, input logic v, input logic fl, input logic pd);
      exp_t e;
      e.pc = pc; e.valid = v; e.flush = fl; e.pend = pd;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic clr_redir();
      jr_control = 1'b0; jump = 1'b0; branch_taken = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; if_ready = 1'b1;
      clr_redir();
      jr_addr = 16'h0; ex_pc_plus2 = 16'h0; jump_field = 13'h0; branch_imm = 7'h0;

      // Reset and sequential fetch
      tick(16'h0000, 0, 0, 0);
      tick(16'h0000, 0, 0, 0);
      rst_n = 1'b1;
      tick(16'h0000, 1, 0, 0);
      for (int a = 2; a <= 16; a += 2) tick(16'(a), 1, 0, 0);

      // JR redirect from 0x0010, low bit of jr_addr dropped
      jr_control = 1'b1; jr_addr = 16'h1235;
      tick(16'h1234, 1, 1, 0);
      clr_redir();
      tick(16'h1236, 1, 0, 0);
      tick(16'h1238, 1, 0, 0);

      // Backward branch wrapping below zero
      branch_taken = 1'b1; ex_pc_plus2 = 16'h0004; branch_imm = 7'h7C;
      tick(16'hFFFC, 1, 1, 0);
      clr_redir();
      tick(16'hFFFE, 1, 0, 0);
      tick(16'h0000, 1, 0, 0);

      // All three flags: JR wins
      jr_control = 1'b1; jump = 1'b1; branch_taken = 1'b1;
      jr_addr = 16'h0200; jump_field = 13'h0AAA; ex_pc_plus2 = 16'h8000; branch_imm = 7'h05;
      tick(16'h0200, 1, 1, 0);
      clr_redir();
      tick(16'h0202, 1, 0, 0);
      jr_control = 1'b1; jr_addr = 16'h0040;
      tick(16'h0040, 1, 1, 0);

      // Jump while memory not ready: latched then released
      clr_redir(); if_ready = 1'b0;
      jump = 1'b1; jump_field = 13'h0100; ex_pc_plus2 = 16'h4000;
      tick(16'h0040, 1, 1, 1);
      clr_redir();
      tick(16'h0040, 1, 0, 1);
      tick(16'h0040, 1, 0, 1);
      if_ready = 1'b1;
      tick(16'h4200, 1, 0, 0);
      tick(16'h4202, 1, 0, 0);

      // Stall hold, even with the request accepted
      stall = 1'b1;
      tick(16'h4202, 1, 0, 0);
      tick(16'h4202, 1, 0, 0);
      tick(16'h4202, 1, 0, 0);

      // Stall plus redirect while not ready: PC moves directly
      if_ready = 1'b0; jr_control = 1'b1; jr_addr = 16'h0301;
      tick(16'h0300, 1, 1, 0);
      stall = 1'b0; clr_redir();
      tick(16'h0300, 1, 0, 0);

      // Pending redirect overwritten by a newer one; stall ignored in PEND
      jr_control = 1'b1; jr_addr = 16'h0500;
      tick(16'h0300, 1, 1, 1);
      clr_redir(); branch_taken = 1'b1; ex_pc_plus2 = 16'h1000; branch_imm = 7'h03;
      tick(16'h0300, 1, 1, 1);
      clr_redir(); stall = 1'b1;
      tick(16'h0300, 1, 0, 1);
      stall = 1'b0; if_ready = 1'b1;
      tick(16'h1006, 1, 0, 0);

      // Reset while a redirect is pending
      if_ready = 1'b0; jr_control = 1'b1; jr_addr = 16'h0700;
      tick(16'h1006, 1, 1, 1);
      rst_n = 1'b0;
      tick(16'h0000, 0, 0, 0);
      rst_n = 1'b1; clr_redir(); if_ready = 1'b1;
      tick(16'h0000, 1, 0, 0);
      tick(16'h0002, 1, 0, 0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
